// File: rtl/dp_share_pkg.sv
// Shared constants and tag type for the datapath-sharing scheduler.
// Operand fields are packed {zero,d,c,b,a} per requester, with a in the LSBs.
package dp_share_pkg;

    localparam int unsigned OP_A     = 0;
    localparam int unsigned OP_B     = 1;
    localparam int unsigned OP_C     = 2;
    localparam int unsigned OP_D     = 3;
    localparam int unsigned OP_ZERO  = 4;
    localparam int unsigned NUM_OPS  = 5;

    // Wide enough for the largest supported requester count (8).
    localparam int unsigned TAG_ID_W = 3;

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from a
// pointer that advances past each winner.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [N-1:0]  i_req,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_idx;
    logic          w_any;
    int unsigned   w_cand;

    always_comb begin
        w_idx  = '0;
        w_any  = 1'b0;
        w_cand = 0;
        for (int unsigned k = 0; k < N; k++) begin
            w_cand = (32'(r_ptr) + k) % N;
            if (!w_any && i_req[IW'(w_cand)]) begin
                w_any = 1'b1;
                w_idx = IW'(w_cand);
            end
        end
    end

    // Grant is suppressed during reset so nothing issues into a clearing pipeline.
    assign o_gnt = (w_any && !i_rst) ? (N'(1) << w_idx) : '0;
    assign o_idx = w_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (32'(w_idx) == N - 1) ? '0 : w_idx + 1'b1;
        end
    end

endmodule

// File: rtl/dp_share_sched.sv
// Shares one pipelined datapath among NUM_REQ requesters: registers the winner's
// operands onto dp_*, tracks each issue with a tag pipeline and routes dp_z back.
module dp_share_sched
    import dp_share_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATAWIDTH  = 64,
    parameter int unsigned DP_LATENCY = 1
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*NUM_OPS*DATAWIDTH-1:0] req_ops,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [DATAWIDTH-1:0]           dp_a,
    output logic [DATAWIDTH-1:0]           dp_b,
    output logic [DATAWIDTH-1:0]           dp_c,
    output logic [DATAWIDTH-1:0]           dp_d,
    output logic [DATAWIDTH-1:0]           dp_zero,
    input  logic [DATAWIDTH-1:0]           dp_z,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATAWIDTH-1:0]           rsp_z,
    output logic [3:0]                     inflight
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned SW = NUM_OPS * DATAWIDTH;

    logic [IW-1:0]        w_idx;
    logic                 w_issue;
    logic                 w_rsp;
    logic [SW-1:0]        w_sel_ops;
    tag_t                 r_tag [DP_LATENCY+1];
    logic [DATAWIDTH-1:0] r_dp_a, r_dp_b, r_dp_c, r_dp_d, r_dp_zero;
    logic [DATAWIDTH-1:0] r_rsp_z;
    logic [3:0]           r_inflight;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .i_clk (Clk),
        .i_rst (Rst),
        .i_req (req),
        .o_gnt (gnt),
        .o_idx (w_idx)
    );

    assign w_issue = |gnt;

    always_comb begin
        w_sel_ops = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) w_sel_ops = req_ops[i*SW +: SW];
        end
    end

    // Operands hold when idle: the downstream datapath is stateful.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_dp_a    <= '0;
            r_dp_b    <= '0;
            r_dp_c    <= '0;
            r_dp_d    <= '0;
            r_dp_zero <= '0;
        end else if (w_issue) begin
            r_dp_a    <= w_sel_ops[OP_A*DATAWIDTH +: DATAWIDTH];
            r_dp_b    <= w_sel_ops[OP_B*DATAWIDTH +: DATAWIDTH];
            r_dp_c    <= w_sel_ops[OP_C*DATAWIDTH +: DATAWIDTH];
            r_dp_d    <= w_sel_ops[OP_D*DATAWIDTH +: DATAWIDTH];
            r_dp_zero <= w_sel_ops[OP_ZERO*DATAWIDTH +: DATAWIDTH];
        end
    end

    assign dp_a    = r_dp_a;
    assign dp_b    = r_dp_b;
    assign dp_c    = r_dp_c;
    assign dp_d    = r_dp_d;
    assign dp_zero = r_dp_zero;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int unsigned k = 0; k <= DP_LATENCY; k++) r_tag[k] <= '0;
        end else begin
            r_tag[0] <= '{vld: w_issue, id: TAG_ID_W'(w_idx)};
            for (int unsigned k = 1; k <= DP_LATENCY; k++) r_tag[k] <= r_tag[k-1];
        end
    end

    assign w_rsp = r_tag[DP_LATENCY].vld && !Rst;

    always_comb begin
        rsp_valid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_rsp && r_tag[DP_LATENCY].id == TAG_ID_W'(i)) rsp_valid[i] = 1'b1;
        end
    end

    assign rsp_z = w_rsp ? dp_z : r_rsp_z;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_rsp_z    <= '0;
            r_inflight <= '0;
        end else begin
            if (w_rsp) r_rsp_z <= dp_z;
            r_inflight <= r_inflight + 4'(w_issue) - 4'(w_rsp);
        end
    end

    assign inflight = r_inflight;

endmodule

// File: tb/tb_dp_share_sched.sv
// Directed + randomized bench for dp_share_sched with a behavioural datapath
// (z = a*b + c*d + zero) and a cycle-accurate response scoreboard.
module tb_dp_share_sched;
    import dp_share_pkg::*;

    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned DATAWIDTH  = 64;
    localparam int unsigned DP_LATENCY = 1;
    localparam int unsigned SW         = NUM_OPS * DATAWIDTH;

    logic                       Clk = 1'b0;
    logic                       Rst;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*SW-1:0]      req_ops;
    logic [NUM_REQ-1:0]         gnt;
    logic [DATAWIDTH-1:0]       dp_a, dp_b, dp_c, dp_d, dp_zero, dp_z;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [DATAWIDTH-1:0]       rsp_z;
    logic [3:0]                 inflight;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int          id;
        logic [63:0] z;
        int          due;
    } exp_t;
    exp_t sb[$];

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    dp_share_sched #(
        .NUM_REQ    (NUM_REQ),
        .DATAWIDTH  (DATAWIDTH),
        .DP_LATENCY (DP_LATENCY)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .req       (req),
        .req_ops   (req_ops),
        .gnt       (gnt),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_c      (dp_c),
        .dp_d      (dp_d),
        .dp_zero   (dp_zero),
        .dp_z      (dp_z),
        .rsp_valid (rsp_valid),
        .rsp_z     (rsp_z),
        .inflight  (inflight)
    );

    function automatic logic [63:0] dp_fn(input logic signed [63:0] a, b, c, d, z);
        return a * b + c * d + z;
    endfunction

    // Behavioural stand-in for the shared datapath.
    logic [63:0] dpz_q [DP_LATENCY];
    always @(posedge Clk) begin
        dpz_q[0] <= dp_fn(dp_a, dp_b, dp_c, dp_d, dp_zero);
        for (int k = 1; k < DP_LATENCY; k++) dpz_q[k] <= dpz_q[k-1];
    end
    assign dp_z = dpz_q[DP_LATENCY-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [63:0] a, b, c, d, z);
        req_ops[i*SW + OP_A*64    +: 64] = a;
        req_ops[i*SW + OP_B*64    +: 64] = b;
        req_ops[i*SW + OP_C*64    +: 64] = c;
        req_ops[i*SW + OP_D*64    +: 64] = d;
        req_ops[i*SW + OP_ZERO*64 +: 64] = z;
    endtask

    task automatic rand_ops(input int i);
        set_ops(i, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, {$urandom, $urandom});
    endtask

    task automatic check_reset_vals();
        check("rst gnt", gnt, 0);
        check("rst rsp_valid", rsp_valid, 0);
        check("rst rsp_z", rsp_z, 0);
        check("rst dp_a", dp_a, 0);
        check("rst dp_b", dp_b, 0);
        check("rst dp_c", dp_c, 0);
        check("rst dp_d", dp_d, 0);
        check("rst dp_zero", dp_zero, 0);
        check("rst inflight", inflight, 0);
    endtask

    // Reference model: arbiter pointer, operand registers and response queue.
    int          m_ptr = 0;
    logic [63:0] m_dp [NUM_OPS];
    logic [63:0] m_last_z = '0;

    always @(negedge Clk) begin : mon
        int                 w;
        int                 cand;
        logic [NUM_REQ-1:0] eg;
        exp_t               e;
        if (mon_en) begin
            w  = -1;
            eg = '0;
            if (!Rst) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    cand = (m_ptr + k) % NUM_REQ;
                    if (w < 0 && req[cand]) w = cand;
                end
            end
            if (w >= 0) eg[w] = 1'b1;
            check("mon gnt", gnt, eg);
            check("mon inflight", inflight, sb.size());
            check("mon dp_a", dp_a, m_dp[OP_A]);
            check("mon dp_b", dp_b, m_dp[OP_B]);
            check("mon dp_c", dp_c, m_dp[OP_C]);
            check("mon dp_d", dp_d, m_dp[OP_D]);
            check("mon dp_zero", dp_zero, m_dp[OP_ZERO]);
            if (!Rst && sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check("mon rsp_valid", rsp_valid, 64'(1) << e.id);
                check("mon rsp_z", rsp_z, e.z);
                m_last_z = e.z;
            end else begin
                check("mon rsp_valid idle", rsp_valid, 0);
                check("mon rsp_z hold", rsp_z, m_last_z);
            end
            if (Rst) begin
                sb.delete();
                m_ptr    = 0;
                m_last_z = '0;
                for (int k = 0; k < NUM_OPS; k++) m_dp[k] = '0;
            end else if (w >= 0) begin
                for (int k = 0; k < NUM_OPS; k++) m_dp[k] = req_ops[w*SW + k*64 +: 64];
                e.id  = w;
                e.z   = dp_fn(m_dp[OP_A], m_dp[OP_B], m_dp[OP_C], m_dp[OP_D], m_dp[OP_ZERO]);
                e.due = cyc + 1 + DP_LATENCY;
                sb.push_back(e);
                m_ptr = (w + 1) % NUM_REQ;
            end
        end
    end

    initial begin
        int pulses;
        for (int k = 0; k < NUM_OPS; k++) m_dp[k] = '0;
        Rst     = 1'b1;
        req     = '0;
        req_ops = '0;
        repeat (2) tick();
        mon_en = 1'b1;

        // Requests during reset must not be granted.
        req = '1;
        @(negedge Clk);
        check("gnt in reset", gnt, 0);
        tick();
        req = '0;
        Rst = 1'b0;
        @(negedge Clk);
        check_reset_vals();

        // Single requester, then idle hold.
        tick();
        set_ops(2, 5, -3, 7, 1, 0);
        req = 4'b0100;
        @(negedge Clk);
        check("single gnt", gnt, 4'b0100);
        pulses = 0;
        for (int j = 1; j <= 5; j++) begin
            tick();
            req = '0;
            @(negedge Clk);
            check("idle gnt", gnt, 0);
            check("idle dp_a", dp_a, 5);
            check("idle dp_b", dp_b, -3);
            if (|rsp_valid) pulses++;
            if (j == 1 + DP_LATENCY) begin
                check("single rsp_valid", rsp_valid, 4'b0100);
                check("single rsp_z", rsp_z, -64'sd8);
            end
        end
        check("idle pulses", pulses, 1);
        check("idle inflight", inflight, 0);

        // Pointer is now 3: wrap and skip.
        tick();
        req = 4'b1010;
        @(negedge Clk);
        check("wrap gnt0", gnt, 4'b1000);
        tick();
        @(negedge Clk);
        check("wrap gnt1", gnt, 4'b0010);
        tick();
        @(negedge Clk);
        check("wrap gnt2", gnt, 4'b1000);
        tick();
        req = '0;
        repeat (DP_LATENCY + 2) tick();

        // All four requesting from reset release.
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) rand_ops(i);
        req = '1;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            check("all gnt order", gnt, 64'(1) << (k % 4));
            check("all inflight", inflight, (k < 1 + DP_LATENCY) ? k : 1 + DP_LATENCY);
            tick();
        end
        req = '0;
        repeat (DP_LATENCY + 2) tick();

        // Reset while two operations are in flight.
        req = '1;
        @(negedge Clk);
        tick();
        @(negedge Clk);
        tick();
        req = '0;
        Rst = 1'b1;
        @(negedge Clk);
        check("midrst inflight", inflight, 2);
        tick();
        Rst = 1'b0;
        @(negedge Clk);
        check_reset_vals();
        for (int j = 0; j < DP_LATENCY + 3; j++) begin
            tick();
            @(negedge Clk);
            check("midrst no rsp", rsp_valid, 0);
        end

        // Randomized traffic; the monitor compares every cycle.
        for (int n = 0; n < 1000; n++) begin
            tick();
            req = NUM_REQ'($urandom);
            for (int i = 0; i < NUM_REQ; i++) rand_ops(i);
        end
        tick();
        req = '0;
        repeat (DP_LATENCY + 3) tick();
        @(negedge Clk);
        check("scoreboard drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
